// File: rtl/gxsim_host_regfile_if.sv
// Host-side register bus for the GenX register file model: command decoder
// drives address/data/strobes, the register file returns read data and bank state.
interface gxsim_host_regfile_if #(
    parameter int BANK_COUNT = 10
);
    logic [31:0]           address;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  write_strobe;
    logic                  read_strobe;
    logic [31:0]           rdata;
    logic                  rvalid;
    logic [BANK_COUNT-1:0] bank_select;
    logic                  bank_change;

    modport master (
        output address, wdata, wstrb, write_strobe, read_strobe,
        input  rdata, rvalid, bank_select, bank_change
    );

    modport slave (
        input  address, wdata, wstrb, write_strobe, read_strobe,
        output rdata, rvalid, bank_select, bank_change
    );
endinterface

// File: rtl/gxsim_host_regfile.sv
// GenX host-register file model: byte-strobed general registers, a bank-enable
// register decoded into a bank bitmap, and a fixed-latency pipelined read path.
module gxsim_host_regfile #(
    parameter int          REG_COUNT        = 16,
    parameter int          BANK_COUNT       = 10,
    parameter logic [31:0] BANK_EN_ADDR     = 32'h28,
    parameter int          READ_LATENCY     = 2,
    parameter bit          SWAP_BANK_ENDIAN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    gxsim_host_regfile_if.slave  bus
);
    localparam int IW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    function automatic logic [31:0] byte_swap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    logic [31:0]           regs [REG_COUNT];
    logic [31:0]           bank_en;
    logic                  hit_bank;
    logic                  hit_gen;
    logic [IW-1:0]         reg_idx;
    logic [31:0]           rd_src;
    logic [31:0]           pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [BANK_COUNT-1:0] bank_sel;
    logic [BANK_COUNT-1:0] bank_sel_q;
    logic                  bank_change_q;

    // The bank-enable address wins over a general register that shares its index.
    assign hit_bank = (bus.address == BANK_EN_ADDR);
    assign hit_gen  = !hit_bank && (bus.address[31:2] < 30'(REG_COUNT));
    assign reg_idx  = bus.address[IW+1:2];

    always_comb begin
        rd_src = byte_swap(bus.address);
        if (hit_bank) begin
            rd_src = bank_en;
        end else if (hit_gen) begin
            rd_src = regs[reg_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_en <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.write_strobe) begin
            for (int n = 0; n < 4; n++) begin
                if (bus.wstrb[n]) begin
                    if (hit_bank) begin
                        bank_en[8*n +: 8] <= bus.wdata[8*n +: 8];
                    end else if (hit_gen) begin
                        regs[reg_idx][8*n +: 8] <= bus.wdata[8*n +: 8];
                    end
                end
            end
        end
    end

    // Data stages only load behind a valid beat, so the last stage holds the
    // most recent read result while rvalid is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= bus.read_strobe;
            if (bus.read_strobe) begin
                pipe_data[0] <= rd_src;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign bus.rdata  = pipe_data[READ_LATENCY-1];
    assign bus.rvalid = pipe_valid[READ_LATENCY-1];

    assign bank_sel = BANK_COUNT'(SWAP_BANK_ENDIAN ? byte_swap(bank_en) : bank_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_sel_q    <= '0;
            bank_change_q <= 1'b0;
        end else begin
            bank_sel_q    <= bank_sel;
            bank_change_q <= (bank_sel != bank_sel_q);
        end
    end

    assign bus.bank_select = bank_sel;
    assign bus.bank_change = bank_change_q;
endmodule

// File: tb/tb_gxsim_host_regfile.sv
// Bench for gxsim_host_regfile: directed vector table, randomized traffic against
// an array/queue reference model, mid-read reset, and a small-REG_COUNT instance.
module tb_gxsim_host_regfile;
    localparam int          REGS = 16;
    localparam int          BC   = 10;
    localparam int          LAT  = 2;
    localparam logic [31:0] BADR = 32'h28;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gxsim_host_regfile_if #(.BANK_COUNT(BC)) bus_a ();
    gxsim_host_regfile_if #(.BANK_COUNT(BC)) bus_b ();

    gxsim_host_regfile #(.REG_COUNT(REGS), .BANK_COUNT(BC), .BANK_EN_ADDR(BADR),
                         .READ_LATENCY(LAT), .SWAP_BANK_ENDIAN(1'b1))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a));

    gxsim_host_regfile #(.REG_COUNT(4), .BANK_COUNT(BC), .BANK_EN_ADDR(BADR),
                         .READ_LATENCY(LAT), .SWAP_BANK_ENDIAN(1'b1))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [BC-1:0] bsel_of(input logic [31:0] v);
        logic [31:0] s;
        s = bswap(v);
        return s[BC-1:0];
    endfunction

    // Reference model: register contents, outstanding reads with due cycle,
    // and the bank bitmap seen in the last two cycles.
    typedef struct {
        int          due;
        logic [31:0] data;
        bit          has_tab;
        logic [31:0] tab;
    } rd_t;

    logic [31:0] mregs [REGS];
    logic [31:0] mbank;
    logic [31:0] last_rdata;
    logic [BC-1:0] hist1, hist2;
    rd_t rq[$];
    int cyc = 0;

    task automatic model_reset();
        for (int i = 0; i < REGS; i++) mregs[i] = '0;
        mbank = '0;
        last_rdata = '0;
        hist1 = '0;
        hist2 = '0;
        rq.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == BADR) return mbank;
        if (int'(a[31:2]) < REGS) return mregs[int'(a[31:2])];
        return bswap(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] v;
        v = old;
        for (int n = 0; n < 4; n++) if (st[n]) v[8*n +: 8] = wd[8*n +: 8];
        return v;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        if (a == BADR) mbank = merge(mbank, wd, st);
        else if (int'(a[31:2]) < REGS) mregs[int'(a[31:2])] = merge(mregs[int'(a[31:2])], wd, st);
    endtask

    task automatic check_outputs();
        logic [BC-1:0] cur;
        bit exp_valid;
        exp_valid = (rq.size() > 0) && (rq[0].due == cyc);
        chk("rvalid", 32'(bus_a.rvalid), 32'(exp_valid));
        if (exp_valid) begin
            chk("rdata_model", bus_a.rdata, rq[0].data);
            if (rq[0].has_tab) chk("rdata_vector", bus_a.rdata, rq[0].tab);
            last_rdata = rq[0].data;
            void'(rq.pop_front());
        end else begin
            chk("rdata_hold", bus_a.rdata, last_rdata);
        end
        cur = bsel_of(mbank);
        chk("bank_select", 32'(bus_a.bank_select), 32'(cur));
        chk("bank_change", 32'(bus_a.bank_change), 32'(hist1 != hist2));
        hist2 = hist1;
        hist1 = cur;
    endtask

    // Drives one cycle of activity (called #1 after an edge), then checks.
    task automatic cycle(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input bit has_tab, input logic [31:0] tab);
        bus_a.read_strobe  = rd;
        bus_a.write_strobe = wr;
        bus_a.address      = a;
        bus_a.wdata        = wd;
        bus_a.wstrb        = st;
        if (rd) rq.push_back('{due: cyc + LAT, data: model_read(a), has_tab: has_tab, tab: tab});
        if (wr) model_write(a, wd, st);
        @(posedge clk);
        #1;
        cyc++;
        bus_a.read_strobe  = 1'b0;
        bus_a.write_strobe = 1'b0;
        check_outputs();
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          has_tab;
        logic [31:0] tab;
        logic [BC-1:0] exp_bsel;
        bit          exp_bc;
    } vec_t;

    vec_t vt [23];

    task automatic read_b(input string name, input logic [31:0] a, input logic [31:0] exp);
        int n;
        bus_b.address = a;
        bus_b.read_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus_b.read_strobe = 1'b0;
        n = 1;
        while (!bus_b.rvalid && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(LAT));
        chk(name, bus_b.rdata, exp);
    endtask

    task automatic write_b(input logic [31:0] a, input logic [31:0] wd);
        bus_b.address = a;
        bus_b.wdata = wd;
        bus_b.wstrb = 4'hF;
        bus_b.write_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus_b.write_strobe = 1'b0;
    endtask

    initial begin
        logic [31:0] a, wd;
        int r;

        vt[0]  = '{1, 0, 32'h00,   32'h0,        4'h0, 1, 32'h0,        10'h000, 0};
        vt[1]  = '{1, 0, 32'h28,   32'h0,        4'h0, 1, 32'h0,        10'h000, 0};
        vt[2]  = '{1, 0, 32'h1000, 32'h0,        4'h0, 1, 32'h00100000, 10'h000, 0};
        vt[3]  = '{0, 1, 32'h04,   32'h11223344, 4'hF, 0, 32'h0,        10'h000, 0};
        vt[4]  = '{0, 1, 32'h04,   32'hAABBCCDD, 4'h5, 0, 32'h0,        10'h000, 0};
        vt[5]  = '{1, 0, 32'h04,   32'h0,        4'h0, 1, 32'h11BB33DD, 10'h000, 0};
        vt[6]  = '{0, 1, 32'h28,   32'h00000003, 4'hF, 0, 32'h0,        10'h000, 0};
        vt[7]  = '{0, 0, 32'h00,   32'h0,        4'h0, 0, 32'h0,        10'h000, 0};
        vt[8]  = '{0, 1, 32'h28,   32'h03000000, 4'hF, 0, 32'h0,        10'h003, 0};
        vt[9]  = '{0, 0, 32'h00,   32'h0,        4'h0, 0, 32'h0,        10'h003, 1};
        vt[10] = '{0, 0, 32'h00,   32'h0,        4'h0, 0, 32'h0,        10'h003, 0};
        vt[11] = '{1, 0, 32'h28,   32'h0,        4'h0, 1, 32'h03000000, 10'h003, 0};
        vt[12] = '{0, 1, 32'h00,   32'h1,        4'hF, 0, 32'h0,        10'h003, 0};
        vt[13] = '{0, 1, 32'h04,   32'h2,        4'hF, 0, 32'h0,        10'h003, 0};
        vt[14] = '{0, 1, 32'h08,   32'h3,        4'hF, 0, 32'h0,        10'h003, 0};
        vt[15] = '{0, 1, 32'h0C,   32'h4,        4'hF, 0, 32'h0,        10'h003, 0};
        vt[16] = '{1, 0, 32'h00,   32'h0,        4'h0, 1, 32'h1,        10'h003, 0};
        vt[17] = '{1, 0, 32'h04,   32'h0,        4'h0, 1, 32'h2,        10'h003, 0};
        vt[18] = '{1, 1, 32'h08,   32'h9,        4'hF, 1, 32'h3,        10'h003, 0};
        vt[19] = '{1, 0, 32'h0C,   32'h0,        4'h0, 1, 32'h4,        10'h003, 0};
        vt[20] = '{1, 0, 32'h08,   32'h0,        4'h0, 1, 32'h9,        10'h003, 0};
        vt[21] = '{0, 0, 32'h00,   32'h0,        4'h0, 0, 32'h0,        10'h003, 0};
        vt[22] = '{0, 0, 32'h00,   32'h0,        4'h0, 0, 32'h0,        10'h003, 0};

        bus_a.address = '0; bus_a.wdata = '0; bus_a.wstrb = '0;
        bus_a.read_strobe = 1'b0; bus_a.write_strobe = 1'b0;
        bus_b.address = '0; bus_b.wdata = '0; bus_b.wstrb = '0;
        bus_b.read_strobe = 1'b0; bus_b.write_strobe = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rvalid", 32'(bus_a.rvalid), 32'h0);
        chk("reset_rdata", bus_a.rdata, 32'h0);
        chk("reset_bank_select", 32'(bus_a.bank_select), 32'h0);
        chk("reset_bank_change", 32'(bus_a.bank_change), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            cycle(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, vt[i].has_tab, vt[i].tab);
            chk($sformatf("vec%0d_bank_select", i), 32'(bus_a.bank_select), 32'(vt[i].exp_bsel));
            chk($sformatf("vec%0d_bank_change", i), 32'(bus_a.bank_change), 32'(vt[i].exp_bc));
        end

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 7));
            case (r)
                0, 1, 2, 3, 4: a = 32'($urandom_range(0, REGS - 1) * 4 + $urandom_range(0, 3));
                5:             a = BADR + 32'($urandom_range(0, 3));
                6:             a = 32'h40 + 32'($urandom_range(0, 63));
                default:       a = $urandom;
            endcase
            wd = (r == 5 && ($urandom_range(0, 1) == 1)) ? 32'h03000000 : $urandom;
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd,
                  4'($urandom_range(0, 15)), 1'b0, 32'h0);
        end
        repeat (LAT + 1) cycle(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);

        // Reset landing on an in-flight read: outputs clear at once, the read is lost.
        cycle(0, 1, BADR, 32'h03000000, 4'hF, 0, 32'h0);
        repeat (2) cycle(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
        chk("pre_reset_bank_select", 32'(bus_a.bank_select), 32'h3);
        cycle(1, 0, 32'h04, 32'h0, 4'h0, 0, 32'h0);
        #1 reset = 1'b1;
        #1;
        chk("midread_rvalid", 32'(bus_a.rvalid), 32'h0);
        chk("midread_rdata", bus_a.rdata, 32'h0);
        chk("midread_bank_select", 32'(bus_a.bank_select), 32'h0);
        chk("midread_bank_change", 32'(bus_a.bank_change), 32'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (LAT + 2) cycle(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
        cycle(1, 0, 32'h04, 32'h0, 4'h0, 1, 32'h0);
        repeat (LAT) cycle(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);

        // Four-register instance: 0x10 is beyond the general bank.
        write_b(32'h0C, 32'h7);
        write_b(32'h10, 32'h5);
        read_b("small_unmapped", 32'h10, 32'h10000000);
        read_b("small_reg0", 32'h00, 32'h0);
        read_b("small_reg3", 32'h0C, 32'h7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
